// File: rtl/piso_stream.sv
// piso_stream: parallel-in/serial-out serializer with a valid/ready word input, selectable bit order and bit period.
// Define PISO_PARITY_EN to append a parity bit (even, or odd when PARITY_ODD=1) after the data bits.
module piso_stream #(
    parameter int WIDTH      = 8,
    parameter int MSB_FIRST  = 0,
    parameter int DIV        = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             sof,
    output logic             eof,
    output logic             busy
);

`ifdef PISO_PARITY_EN
    localparam int FL = WIDTH + 1;
`else
    localparam int FL = WIDTH;
`endif
    localparam int BCW = $clog2(FL + 1);
    localparam int DCW = $clog2(DIV + 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(FL - 1);
    localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);

    generate
        if (WIDTH < 2 || DIV < 1 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
            $error("piso_stream: illegal parameter combination");
        end
    endgenerate

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t         state;
    state_t         state_next;
    logic [FL-1:0]  shreg;
    logic [FL-1:0]  load_word;
    logic [BCW-1:0] bit_cnt;
    logic [DCW-1:0] div_cnt;
    logic           bit_done;
    logic           frame_last;
    logic           accept;

    // Ready is asserted on the final cycle of a frame so words can stream back-to-back.
    always_comb begin
        bit_done   = (div_cnt == DIV_LAST);
        frame_last = (state == SHIFT) && bit_done && (bit_cnt == BIT_LAST);
        din_ready  = (state == IDLE) || frame_last;
        accept     = din_valid && din_ready;
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = SHIFT;
            SHIFT:   if (frame_last && !accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The frame is laid out so that the shift direction always pushes the next bit to the output end.
    always_comb begin
        load_word = '0;
`ifdef PISO_PARITY_EN
        if (MSB_FIRST != 0) load_word = {din, (^din) ^ (PARITY_ODD != 0)};
        else                load_word = {(^din) ^ (PARITY_ODD != 0), din};
`else
        load_word = din;
`endif
    end

    always_comb begin
        dout_valid = (state == SHIFT);
        busy       = dout_valid;
        sof        = dout_valid && (bit_cnt == '0);
        eof        = dout_valid && (bit_cnt == BIT_LAST);
        dout       = 1'b0;
        if (dout_valid) dout = (MSB_FIRST != 0) ? shreg[FL-1] : shreg[0];
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
        end else if (accept) begin
            shreg   <= load_word;
            bit_cnt <= '0;
            div_cnt <= '0;
        end else if (state == SHIFT) begin
            if (bit_done) begin
                div_cnt <= '0;
                bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
                if (MSB_FIRST != 0) shreg <= {shreg[FL-2:0], 1'b0};
                else                shreg <= {1'b0, shreg[FL-1:1]};
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_piso_stream.sv
// tb_piso_stream: two piso_stream instances (LSB-first DIV=1 even parity, MSB-first DIV=3 odd parity)
// checked every cycle against a frame-position model, plus literal expectations for the directed vectors.
module tb_piso_stream;

`ifdef PISO_PARITY_EN
    localparam int FL_TB = 9;
`else
    localparam int FL_TB = 8;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] din_a, din_b;
    logic       valid_a, valid_b;
    logic       ready_a, ready_b;
    logic       dout_a, dout_b;
    logic       dv_a, dv_b;
    logic       sof_a, sof_b;
    logic       eof_a, eof_b;
    logic       busy_a, busy_b;

    int tests = 0;
    int fails = 0;
    bit check_en = 0;

    piso_stream #(.WIDTH(8), .MSB_FIRST(0), .DIV(1), .PARITY_ODD(0)) dut_a (
        .clk(clk), .rst(rst), .din(din_a), .din_valid(valid_a), .din_ready(ready_a),
        .dout(dout_a), .dout_valid(dv_a), .sof(sof_a), .eof(eof_a), .busy(busy_a)
    );

    piso_stream #(.WIDTH(8), .MSB_FIRST(1), .DIV(3), .PARITY_ODD(1)) dut_b (
        .clk(clk), .rst(rst), .din(din_b), .din_valid(valid_b), .din_ready(ready_b),
        .dout(dout_b), .dout_valid(dv_b), .sof(sof_b), .eof(eof_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, actual, expected);
        end
    endtask

    // Model: per instance, the position (in clk cycles) within the current frame, -1 when idle.
    int              m_pos[2] = '{-1, -1};
    logic [FL_TB-1:0] m_seq[2];

    function automatic int divOf(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic [FL_TB-1:0] frameBits(input logic [7:0] w, input bit msb, input bit odd);
        logic [FL_TB-1:0] f;
        f = '0;
        for (int i = 0; i < 8; i++) f[i] = msb ? w[7-i] : w[i];
`ifdef PISO_PARITY_EN
        f[8] = (^w) ^ odd;
`endif
        return f;
    endfunction

    task automatic modelStep(input int k, input logic v, input logic [7:0] w);
        int len;
        bit rdy;
        len = FL_TB * divOf(k);
        rdy = (m_pos[k] < 0) || (m_pos[k] == len - 1);
        if (rst)                m_pos[k] = -1;
        else if (v && rdy) begin
            m_pos[k] = 0;
            m_seq[k] = frameBits(w, k == 1, k == 1);
        end
        else if (m_pos[k] >= 0) m_pos[k] = (m_pos[k] == len - 1) ? -1 : m_pos[k] + 1;
    endtask

    always @(posedge clk) begin
        modelStep(0, valid_a, din_a);
        modelStep(1, valid_b, din_b);
    end

    // Outputs packed as {din_ready, dout, dout_valid, sof, eof, busy}.
    always @(negedge clk) begin
        if (check_en) begin
            for (int k = 0; k < 2; k++) begin
                int  idx;
                bit  mv;
                logic [5:0] exp_v, act_v;
                mv  = m_pos[k] >= 0;
                idx = mv ? m_pos[k] / divOf(k) : 0;
                exp_v = {(!mv) || (m_pos[k] == FL_TB * divOf(k) - 1),
                         mv ? m_seq[k][idx] : 1'b0, mv, mv && idx == 0, mv && idx == FL_TB - 1, mv};
                act_v = (k == 0) ? {ready_a, dout_a, dv_a, sof_a, eof_a, busy_a}
                                 : {ready_b, dout_b, dv_b, sof_b, eof_b, busy_b};
                checkOutput((k == 0) ? "a_cycle" : "b_cycle", int'(act_v), int'(exp_v));
            end
        end
    end

    task automatic applyStimulus(input int k, input logic [7:0] w);
        if (k == 0) begin din_a = w; valid_a = 1'b1; end
        else        begin din_b = w; valid_b = 1'b1; end
        @(negedge clk);
        valid_a = 1'b0;
        valid_b = 1'b0;
    endtask

    task automatic collectFrame(input int k, output logic [15:0] bits, output logic [15:0] sofm,
                                output logic [15:0] eofm, output int dvcnt);
        int d;
        d = divOf(k);
        bits = '0; sofm = '0; eofm = '0; dvcnt = 0;
        for (int c = 0; c < FL_TB * d; c++) begin
            if (c % d == 0) begin
                bits[c/d] = (k == 0) ? dout_a : dout_b;
                sofm[c/d] = (k == 0) ? sof_a : sof_b;
                eofm[c/d] = (k == 0) ? eof_a : eof_b;
            end
            if ((k == 0) ? dv_a : dv_b) dvcnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [15:0] bits, sofm, eofm;
        logic [31:0] dvm, sm, em;
        int dvcnt, rdycnt, rdyat;

        rst = 1'b1; din_a = '0; din_b = '0; valid_a = 1'b0; valid_b = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_en = 1;
        checkOutput("reset_ready_a", int'(ready_a), 1);
        checkOutput("reset_outputs_a", int'({dout_a, dv_a, sof_a, eof_a, busy_a}), 0);
        checkOutput("reset_outputs_b", int'({dout_b, dv_b, sof_b, eof_b, busy_b}), 0);

        // LSB-first, DIV=1: 8'hA5
        applyStimulus(0, 8'hA5);
        collectFrame(0, bits, sofm, eofm, dvcnt);
        checkOutput("a5_bits", int'(bits[7:0]), 8'hA5);
        checkOutput("a5_sof", int'(sofm), 1);
        checkOutput("a5_eof", int'(eofm), 1 << (FL_TB - 1));
        checkOutput("a5_valid_cycles", dvcnt, FL_TB);
        checkOutput("a5_after_valid", int'(dv_a), 0);

        // MSB-first, DIV=3: 8'hC3, with an offered 8'h55 mid-frame that must be ignored
        applyStimulus(1, 8'hC3);
        bits = '0; dvcnt = 0; rdycnt = 0; rdyat = -1;
        for (int c = 0; c < FL_TB * 3; c++) begin
            if (c % 3 == 0) bits[c/3] = dout_b;
            if (dv_b) dvcnt++;
            if (ready_b) begin rdycnt++; rdyat = c; end
            if (c == 4) begin din_b = 8'h55; valid_b = 1'b1; end
            if (c == 8) valid_b = 1'b0;
            @(negedge clk);
        end
        checkOutput("c3_bits", int'(bits[7:0]), 8'hC3);
        checkOutput("c3_valid_cycles", dvcnt, FL_TB * 3);
        checkOutput("c3_ready_count", rdycnt, 1);
        checkOutput("c3_ready_at", rdyat, FL_TB * 3 - 1);
        checkOutput("c3_after_valid", int'(dv_b), 0);
`ifdef PISO_PARITY_EN
        checkOutput("c3_odd_parity", int'(bits[8]), 1);
`endif

        // Back-to-back, DIV=1: 8'hFF then 8'h00 with din_valid held high
        din_a = 8'hFF; valid_a = 1'b1;
        dvm = '0; sm = '0; em = '0;
        for (int c = 0; c < 2 * FL_TB + 2; c++) begin
            @(negedge clk);
            dvm[c] = dv_a; sm[c] = sof_a; em[c] = eof_a;
            if (c == 0) din_a = 8'h00;
            if (c == FL_TB) valid_a = 1'b0;
        end
        checkOutput("b2b_valid_mask", int'(dvm), (1 << (2 * FL_TB)) - 1);
        checkOutput("b2b_sof_mask", int'(sm), 1 | (1 << FL_TB));
        checkOutput("b2b_eof_mask", int'(em), (1 << (FL_TB - 1)) | (1 << (2 * FL_TB - 1)));

        // Reset in cycle 4 of an 8'h0F frame; reset together with din_valid accepts nothing
        applyStimulus(0, 8'h0F);
        repeat (3) @(negedge clk);
        rst = 1'b1; din_a = 8'hAA; valid_a = 1'b1;
        @(negedge clk);
        rst = 1'b0; valid_a = 1'b0;
        checkOutput("rst_outputs", int'({dout_a, dv_a, sof_a, eof_a, busy_a}), 0);
        checkOutput("rst_ready", int'(ready_a), 1);
        applyStimulus(0, 8'h01);
        collectFrame(0, bits, sofm, eofm, dvcnt);
        checkOutput("post_rst_bits", int'(bits[7:0]), 8'h01);
        checkOutput("post_rst_valid_cycles", dvcnt, FL_TB);

`ifdef PISO_PARITY_EN
        // 8'h07 has three ones: even parity bit 1, odd parity bit 0
        applyStimulus(0, 8'h07);
        collectFrame(0, bits, sofm, eofm, dvcnt);
        checkOutput("even_parity_bit", int'(bits[8]), 1);
        checkOutput("even_parity_eof", int'(eofm), 1 << 8);
        applyStimulus(1, 8'h07);
        collectFrame(1, bits, sofm, eofm, dvcnt);
        checkOutput("odd_parity_bit", int'(bits[8]), 0);
        checkOutput("odd_parity_eof", int'(eofm), 1 << 8);
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
